// File: rtl/ram_req_ctrl.sv
// rtl/ram_req_ctrl.sv - request-side sequencer for a single-port synchronous RAM
// Owns the RAM pins and data bus; read data returns on a registered, backpressured port.
module ram_req_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic slot_free;
  logic accept;
  logic capture;
  logic ready;

  assign slot_free = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    capture     = 1'b0;
    ready       = 1'b0;

    case (state_q)
      IDLE, WRITE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        // A full, unconsumed response slot stalls the read with the RAM still enabled.
        if (slot_free) begin
          capture = 1'b1;
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = req_we ? WRITE : RD_ADDR;
      addr_d  = req_addr;
      if (req_we) begin
        wdata_d = req_wdata;
      end
    end

    if (capture) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = ram_data;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    cs_d = (state_d != IDLE);
    we_d = (state_d == WRITE);
    oe_d = (state_d == RD_ADDR) || (state_d == RD_DATA);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_cs    = cs_q;
  assign ram_we    = we_q;
  assign ram_oe    = oe_q;
  assign ram_addr  = addr_q;
  assign ram_data  = (we_q && !oe_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb/tb_ram_req_ctrl.sv - directed self-checking bench for ram_req_ctrl
// Includes a behavioural single-port synchronous RAM on the shared bus.
module tb_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [3:0]  ram_addr;
  wire  [15:0] ram_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_req_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data)
  );

  // Behavioural RAM: writes and read-registers at the edge, drives bus while oe && !we.
  logic [15:0] mem [16];
  logic [15:0] dout = '0;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we && !ram_oe) mem[ram_addr] <= ram_data;
      else if (!ram_we) dout <= mem[ram_addr];
    end
  end

  assign ram_data = (ram_cs && ram_oe && !ram_we) ? dout : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic r, input logic v, input logic we, input logic [3:0] a,
                     input logic [15:0] wd, input logic rr);
    @(posedge clk);
    #1;
    rstn      = r;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    rsp_ready = rr;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset held with a pending write request
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 4'd9, 16'hBEEF, 1'b1);
      check("rst_cs", ram_cs, 0);
      check("rst_we", ram_we, 0);
      check("rst_oe", ram_oe, 0);
      check("rst_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("post_rst_cs", ram_cs, 0);

    // Back-to-back writes addr 0..15
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) cyc(1'b1, 1'b1, 1'b1, 4'(i), 16'hA000 + 16'(i), 1'b1);
      else        cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
      if (i < 16) check("wr_ready", req_ready, 1);
      if (i > 0) begin
        check("wr_cs", ram_cs, 1);
        check("wr_we", ram_we, 1);
        check("wr_oe", ram_oe, 0);
        check("wr_addr", ram_addr, i - 1);
        check("wr_data", ram_data, 16'hA000 + 16'(i - 1));
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("wr_idle_cs", ram_cs, 0);

    // Read-back: accepts on every other edge, response two cycles after each accept
    for (int c = 0; c < 36; c++) begin
      cyc(1'b1, (c < 32), 1'b0, 4'(c / 2), 16'h0, 1'b1);
      if (c < 33) check("rd_ready", req_ready, (c % 2 == 0));
      check("rd_rsp_valid", rsp_valid, (c >= 3 && c <= 33 && (c % 2 == 1)));
      if (c >= 3 && c <= 33 && (c % 2 == 1))
        check("rd_rdata", rsp_rdata, 16'hA000 + 16'((c - 3) / 2));
    end

    // Backpressure: read 3 then read 5 with the consumer stalled
    cyc(1'b1, 1'b1, 1'b0, 4'd3, 16'h0, 1'b0);
    check("bp_ready0", req_ready, 1);
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 16'h0, 1'b0);
    check("bp_ready_rdaddr", req_ready, 0);
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 16'h0, 1'b0);
    check("bp_ready_rddata", req_ready, 1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("bp_valid1", rsp_valid, 1);
    check("bp_data1", rsp_rdata, 16'hA003);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("bp_stall_ready", req_ready, 0);
    check("bp_stall_oe", ram_oe, 1);
    check("bp_hold_data", rsp_rdata, 16'hA003);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("bp_stall_data2", rsp_rdata, 16'hA003);
    check("bp_release_ready", req_ready, 1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    check("bp_valid2", rsp_valid, 1);
    check("bp_data2", rsp_rdata, 16'hA005);
    check("bp_idle_cs", ram_cs, 0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("bp_still_valid", rsp_valid, 1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("bp_consumed", rsp_valid, 0);

    // Write then immediate read of the same address
    cyc(1'b1, 1'b1, 1'b1, 4'd7, 16'h1234, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 4'd7, 16'h0, 1'b1);
    check("mx_we", ram_we, 1);
    check("mx_addr", ram_addr, 7);
    check("mx_wdata", ram_data, 16'h1234);
    check("mx_ready", req_ready, 1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("mx_rdaddr_cs", ram_cs, 1);
    check("mx_rdaddr_oe", ram_oe, 1);
    check("mx_rdaddr_we", ram_we, 0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("mx_no_rsp_yet", rsp_valid, 0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("mx_rsp_valid", rsp_valid, 1);
    check("mx_rsp_data", rsp_rdata, 16'h1234);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);

    // Reset while in RD_ADDR drops the read
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 16'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("mr_in_rdaddr", ram_oe, 1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    check("mr_cs", ram_cs, 0);
    check("mr_oe", ram_oe, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
      check("mr_no_stale", rsp_valid, 0);
      check("mr_idle_cs", ram_cs, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_req_ctrl.md
Name: ram_req_ctrl

Overview:
Request-side controller that sits directly upstream of single_port_sync_ram and owns its cs/we/oe/addr pins and the shared tristate data bus. It accepts read and write requests over a valid/ready interface, sequences the RAM's synchronous access timing, and returns read data on a registered response port with backpressure. Writes are single-cycle and reads two-cycle on the RAM bus, and back-to-back requests are supported without idle cycles.

Parameters:
ADDR_WIDTH, 4, RAM address width; the RAM depth is 2**ADDR_WIDTH.
DATA_WIDTH, 16, data width of the RAM bus and the request/response words.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rstn  input  1  reset, synchronous and active-low.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  request address.
req_wdata  input  DATA_WIDTH  write data; ignored for reads.
rsp_valid  output  1  read data valid.
rsp_ready  input  1  consumer accepts the response.
rsp_rdata  output  DATA_WIDTH  read data.
ram_cs  output  1  RAM chip select.
ram_we  output  1  RAM write enable.
ram_oe  output  1  RAM output enable.
ram_addr  output  ADDR_WIDTH  RAM address.
ram_data  inout  DATA_WIDTH  shared RAM data bus.

Behaviour:
- Reset (rstn low at a clk edge): state IDLE; ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0; the write-data register is 0 and ram_data is released (Z). rsp_valid=0 and rsp_rdata=0. Reset takes priority over everything. An in-flight read is dropped with no response, and an in-flight write may or may not have landed.
- Handshake: a request is accepted at an edge where req_valid && req_ready. A response is consumed at an edge where rsp_valid && rsp_ready.
- RAM pins are registered outputs and are driven from the FSM state:
  - IDLE: cs=0, we=0, oe=0.
  - WRITE: cs=1, we=1, oe=0.
  - RD_ADDR: cs=1, we=0, oe=1.
  - RD_DATA: cs=1, we=0, oe=1.
- ram_data is driven with the write-data register only while ram_we=1 && ram_oe=0; otherwise it is Z.
- FSM states are IDLE, WRITE, RD_ADDR and RD_DATA. On acceptance, the next state is WRITE if req_we=1 and RD_ADDR otherwise. ram_addr and the write data are latched at the same edge.
  - IDLE: waits for acceptance.
  - WRITE: lasts one cycle; the RAM writes at the closing edge. It goes to the next accepted op, or to IDLE.
  - RD_ADDR: lasts one cycle; the RAM registers mem[addr] at the closing edge. Always goes to RD_DATA.
  - RD_DATA: the RAM drives ram_data. If the slot is free (!rsp_valid || rsp_ready), ram_data is captured into rsp_rdata, rsp_valid is set to 1, and the FSM goes to the next accepted op or to IDLE. If the slot is not free, the FSM stays in RD_DATA with cs/oe held and retries next cycle.
- req_ready = (state==IDLE) || (state==WRITE) || (state==RD_DATA && (!rsp_valid || rsp_ready)). It is 0 in RD_ADDR.
- rsp_valid clears on consumption unless a new capture happens at the same edge; if it does, it stays 1 with the new data.
- Read latency is two cycles from the acceptance edge to rsp_valid=1.
- Throughput:
  - Back-to-back writes: 1 per cycle.
  - Reads: 1 per 2 cycles.
  - Read followed by write: the write's cycle immediately follows RD_DATA; the RAM releases the bus when oe drops, with no turnaround cycle.
- Address wrap: addresses are taken verbatim with no range check; the full 2**ADDR_WIDTH space is valid.
- Responses come back strictly in request order; there is at most one outstanding response.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with req_valid=1 -> ram_cs=0, req_ready=1, rsp_valid=0, ram_data=Z, and no request accepted.
- Back-to-back writes: 16 writes, addr 0..15, data 16'hA000+addr, req_valid held high -> 16 consecutive WRITE cycles, req_ready=1 throughout, ram_we=1, ram_data matches each word.
- Read-back: 16 reads of addr 0..15 with rsp_ready=1 -> rsp_valid pulses every 2nd cycle, the first one 2 cycles after the first accept, with rsp_rdata=16'hA000+addr in order.
- Backpressure: read addr 3, then addr 5, with rsp_ready=0 -> the first response (16'hA003) is held. The second read stalls in RD_DATA with req_ready=0. After rsp_ready=1 for one cycle, 16'hA005 appears on the next cycle.
- Mixed: write 16'h1234 to addr 7, then immediately read addr 7 -> rsp_rdata=16'h1234 with no idle cycle between WRITE and RD_ADDR.
- Reset mid-read: rstn=0 during RD_ADDR -> next cycle state is IDLE, rsp_valid stays 0, and no stale response is seen after reset release.
